// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the four-requester round-robin arbiter.
//   NREQ        : number of requesters
//   IDXW        : width of a requester index
//   idx_t       : requester index / rotation pointer type (wraps mod 4)
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    typedef logic [IDXW-1:0] idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/arb_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
// Purely combinational round-robin winner selection.
//
// Ports:
//   req      [3:0] in  : request vector, bit i is requester i
//   last_ptr [1:0] in  : most recently served requester; search starts after it
//   win_idx  [1:0] out : index of the winning requester
//   win_vld        out : at least one request is present
//
// The request vector is rotated right by last_ptr+1 so that the first
// requester in search order lands at bit 0. A lowest-first priority encode
// on the rotated vector gives the position in search order, and adding the
// offset back (mod 4) turns it into the real requester index.
// ---------------------------------------------------------------------------
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_ptr,
    output logic [IDXW-1:0] win_idx,
    output logic            win_vld
);

    idx_t            w_off;
    logic [NREQ-1:0] w_rot;
    idx_t            w_enc;

    always_comb begin
        w_off = last_ptr + 2'd1;

        // Rotated bit i is the requester i steps into the search order.
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = req[idx_t'(idx_t'(i) + w_off)];
        end

        // Scan from the top down so the lowest set bit is the last one written.
        w_enc = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = idx_t'(i);
            end
        end

        win_idx = w_enc + w_off;
        win_vld = |req;
    end

endmodule : arb_rr_pick

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter. One requester holds the shared
// resource until done; priority then rotates so the just-served requester
// is searched last. Re-arbitration happens in the done cycle, so a waiting
// requester is granted on the next edge with no idle bubble.
//
// Optional feature (macro ARB_TIMEOUT_EN): an 8-bit hold counter forces a
// release after MAX_HOLD BUSY cycles without done, pulsing timeout for one
// cycle together with the grant change. Without the macro no counter exists
// and timeout is tied low.
//
// Parameters:
//   MAX_HOLD : BUSY cycles before forced release (2..255, timeout build only)
//
// Ports:
//   clk            in  : rising-edge clock
//   rst_n          in  : asynchronous active-low reset
//   req      [3:0] in  : request vector
//   done           in  : one-cycle completion pulse from the resource
//   gnt      [3:0] out : registered one-hot grant
//   gnt_idx  [1:0] out : registered binary index of the grant
//   gnt_valid      out : registered, a grant is active
//   timeout        out : registered one-cycle forced-release pulse
// ---------------------------------------------------------------------------
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be in 2..255");
    end

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    idx_t            r_last_ptr;
    idx_t            w_last_ptr_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    idx_t            r_gnt_idx;
    idx_t            w_gnt_idx_nxt;
    logic            r_gnt_valid;
    logic            w_gnt_valid_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;

    logic            w_expire;
    logic            w_release;
    logic            w_load;
    idx_t            w_pick_ptr;
    idx_t            w_win_idx;
    logic            w_win_vld;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;

    // Counter restarts with each new grant, so it measures the current hold only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_load) begin
            r_hold_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_expire = (r_state == BUSY) && (r_hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign w_expire = 1'b0;
`endif

    // Releasing the grant behaves as if last_ptr had already moved to the
    // current holder, so the picker sees the rotated order in the same cycle.
    assign w_release  = (r_state == BUSY) && (done || w_expire);
    assign w_pick_ptr = w_release ? r_gnt_idx : r_last_ptr;

    arb_rr_pick u_pick (
        .req      (req),
        .last_ptr (w_pick_ptr),
        .win_idx  (w_win_idx),
        .win_vld  (w_win_vld)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_last_ptr_nxt  = r_last_ptr;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        w_load          = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_load = 1'b1;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_last_ptr_nxt = r_gnt_idx;
                    // A real done in the same cycle wins over the forced release.
                    w_timeout_nxt  = w_expire && !done;
                    if (w_win_vld) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt     = IDLE;
                        w_gnt_nxt       = '0;
                        w_gnt_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt     = BUSY;
            w_gnt_nxt       = NREQ'(1) << w_win_idx;
            w_gnt_idx_nxt   = w_win_idx;
            w_gnt_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_ptr  <= 2'b11;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_ptr  <= w_last_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_vec;
    int n_bad;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
    } vec_t;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] i,
                             input logic v, input logic t);
        check({name, ".gnt"},       {4'h0, gnt},       {4'h0, g});
        check({name, ".gnt_idx"},   {6'h0, gnt_idx},   {6'h0, i});
        check({name, ".gnt_valid"}, {7'h0, gnt_valid}, {7'h0, v});
        check({name, ".timeout"},   {7'h0, timeout},   {7'h0, t});
    endtask

    // Structural invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv.onehot", {7'h0, ($countones(gnt) <= 1)}, 8'h1);
            check("inv.valid_or", {7'h0, gnt_valid}, {7'h0, |gnt});
            if (gnt_valid) begin
                check("inv.idx_match", {4'h0, gnt}, {4'h0, 4'b0001 << gnt_idx});
            end
        end
    end

    vec_t vecs[$];

    initial begin
        logic [1:0] cur;
        n_vec = 0;
        n_bad = 0;
        req   = '0;
        done  = 1'b0;
        rst_n = 1'b0;

        // req, done -> expected gnt, idx, valid after the next edge
        vecs = '{
            '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1},  // first grant, order 0..3
            '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1},
            '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1},  // done -> rotate to 1
            '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1},
            '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1},  // rotate to 2
            '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1},  // req dropped, grant held
            '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1},
            '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0},  // release, idx holds 2
            '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0},  // done in IDLE ignored
            '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1},  // last_ptr=2 -> 3 first
            '{4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1},  // last_ptr=3 -> wrap to 0
            '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1},  // last_ptr=0 -> 3
            '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1},
            '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1},  // sole requester wins again
            '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0},  // release to IDLE, last_ptr=0
            '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1}   // order now starts at 1
        };

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].req, vecs[k].done);
            check_out($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].vld, 1'b0);
        end

        // Asynchronous reset between edges while BUSY with grant 1.
        req  = 4'b1111;
        done = 1'b0;
        #3;
        rst_n = 1'b0;
        #2;
        check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        step(4'b1111, 1'b0);
        check_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        // done every third cycle: grants rotate with no idle bubble.
        cur = 2'd0;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                step(4'b1111, c == 2);
                if (c == 2) cur = cur + 2'd1;
                check_out($sformatf("rot%0d_%0d", g, c), 4'b0001 << cur, cur, 1'b1, 1'b0);
            end
        end

        // Hold behaviour with done never pulsed.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step(4'b0011, 1'b0);
        check_out("hold_load", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 3; c++) begin
            step(4'b0011, 1'b0);
            check_out($sformatf("to_wait%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(4'b0011, 1'b0);
        check_out("to_fire", 4'b0010, 2'd1, 1'b1, 1'b1);
        step(4'b0011, 1'b0);
        check_out("to_after", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        for (int c = 0; c < 100; c++) begin
            step(4'b0011, 1'b0);
            check_out($sformatf("hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_rr_arbiter4

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource among requesters.
- Grants one requester at a time, holds the grant until the resource signals completion, then rotates priority.
- Winner selection uses a 4-to-2 priority encode on a rotated request vector; the result is a registered one-hot grant plus index.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release. Used only with ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit i is requester i
- done  input  1  one-cycle pulse from the resource; ends the current grant
- gnt  output  4  one-hot grant, registered
- gnt_idx  output  2  binary index of the granted requester, registered
- gnt_valid  output  1  a grant is active, registered
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset values: gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, state=IDLE, last_ptr=2'b11. After reset the search order is 0,1,2,3.
- Search order: start at last_ptr+1 (mod 4) and wrap. The first set req bit in that order wins.
- FSM states: IDLE and BUSY.
- IDLE:
  - If |req is set, the next edge loads gnt/gnt_idx with the winner, sets gnt_valid=1 and moves to BUSY. Latency from req to gnt is 1 cycle.
  - If req is all zero, stay in IDLE.
  - done in IDLE is ignored.
- BUSY:
  - gnt, gnt_idx and gnt_valid hold steady, even if the granted requester drops req.
  - done=1 sets last_ptr<=gnt_idx.
  - In the same cycle, if |req (the live req vector), re-arbitrate using the new order. The new grant appears on the next edge with no idle bubble.
  - The just-served requester is searched last, so it wins again only if it is the sole requester.
  - If no req at done, the next edge clears gnt/gnt_valid (gnt_idx holds its last value) and moves to IDLE.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_valid==|gnt.
  - gnt_idx matches gnt whenever gnt_valid=1.
- Arithmetic: all pointer arithmetic is 2-bit and wraps naturally; 3+1=0.
- Reset asserted mid-grant: immediate return to reset values, regardless of clk.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- With the macro:
  - An 8-bit hold counter clears on every grant load and increments each BUSY cycle.
  - If it reaches MAX_HOLD-1 without done, treat that cycle as done: same rotation and re-arbitration.
  - timeout pulses high for exactly that one cycle, registered with the grant change.
  - done and timeout in the same cycle count as done; timeout stays 0.
- Without the macro:
  - No counter is instantiated and grants may be held indefinitely.
  - timeout is tied to 0.

Decomposition:
- Package arb_pkg holds:
  - NREQ=4 and IDXW=2 constants
  - the arb_state_t enum {IDLE, BUSY}
  - the idx_t typedef (logic [1:0])
- Sub-module arb_rr_pick is purely combinational:
  - inputs: req[3:0], last_ptr[1:0]
  - outputs: win_idx[1:0], win_vld
  - operation: rotate req right by last_ptr+1, priority-encode lowest-first, add the offset back mod 4.
  - It is the only place selection logic lives.

Test Plan:
- After reset, req=4'b1111 -> next cycle gnt=4'b0001, gnt_idx=0, gnt_valid=1.
- req held at 4'b1111 with done pulsed every 3rd cycle -> grants rotate 0,1,2,3,0 with no idle cycle between them.
- Grant to 2 active, req drops to 4'b0000 before done -> gnt stays 4'b0100 until done. The cycle after done gives gnt_valid=0 and gnt_idx=2.
- last_ptr=3, req=4'b1001 -> winner 0. Then done with req=4'b1001 -> winner 3. Confirms wrap-around.
- rst_n pulsed low asynchronously mid-BUSY between clock edges -> outputs go to reset values immediately. First grant after release follows order 0..3.
- ARB_TIMEOUT_EN, MAX_HOLD=4, done never pulsed, req=4'b0011 -> timeout pulses high for one cycle after 4 BUSY cycles and gnt moves 0→1. Without the macro, gnt stays 4'b0001 for 100 cycles and timeout stays 0.
